// File: rtl/fb_swap_ctrl_pkg.sv
// Shared scan-out parameters for the pixel RAM path: unit grid, FSM state encodings and the clear colour.
// The clear colour is packed {b,g,r}, 4 bits each, to match the scan-out din.
package fb_swap_ctrl_pkg;

   localparam int UNIT_WIDTH = 3;
   localparam int H_VISIBLE  = 640;
   localparam int V_VISIBLE  = 480;
   localparam int COL_WIDTH  = 7;
   localparam int ROW_WIDTH  = 6;
   localparam int SCAN_COLS  = H_VISIBLE >> UNIT_WIDTH;
   localparam int SCAN_ROWS  = V_VISIBLE >> UNIT_WIDTH;

   localparam logic [11:0] BG_COLOR_DEF = 12'h000;

   typedef enum logic [1:0] {
      ST_RENDER  = 2'd0,
      ST_PENDING = 2'd1,
      ST_CLEAR   = 2'd2
   } fb_state_e;

endpackage

// File: rtl/fb_clear_seq.sv
// Row-major raster counter that visits every (row, col) of one bank, one address per cycle.
// A start pulse arms it at (0,0); last flags the final address and busy drops after it.
module fb_clear_seq
   import fb_swap_ctrl_pkg::*;
#(
   parameter int COL_W = COL_WIDTH,
   parameter int ROW_W = ROW_WIDTH,
   parameter int COLS  = SCAN_COLS,
   parameter int ROWS  = SCAN_ROWS
) (
   input  logic             vga_clk,
   input  logic             rst,
   input  logic             start,
   output logic [ROW_W-1:0] row,
   output logic [COL_W-1:0] col,
   output logic             busy,
   output logic             last
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge vga_clk or negedge rst) begin
      if (!rst) begin
         busy <= 1'b0;
         row  <= '0;
         col  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         row  <= '0;
         col  <= '0;
      end else if (busy) begin
         if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) begin
               busy <= 1'b0;
               row  <= '0;
            end else begin
               row <= row + ROW_W'(1);
            end
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   assign last = busy && (row == ROW_LAST) && (col == COL_LAST);

endmodule

// File: rtl/fb_swap_ctrl.sv
// Double-buffer controller: scan-out reads the front bank, renderer writes the back bank,
// banks swap on the first vs rising edge after frame_done. Define FB_CLEAR_EN to clear the new back bank after each swap.
module fb_swap_ctrl
   import fb_swap_ctrl_pkg::*;
#(
   parameter int          COL_W    = COL_WIDTH,
   parameter int          ROW_W    = ROW_WIDTH,
   parameter int          COLS     = SCAN_COLS,
   parameter int          ROWS     = SCAN_ROWS,
   parameter logic [11:0] BG_COLOR = BG_COLOR_DEF
) (
   input  logic                   vga_clk,
   input  logic                   rst,
   input  logic                   vs,
   input  logic [COL_W-1:0]       scan_col,
   input  logic [ROW_W-1:0]       scan_row,
   output logic [ROW_W+COL_W:0]   rd_addr,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [COL_W-1:0]       wr_col,
   input  logic [ROW_W-1:0]       wr_row,
   input  logic [11:0]            wr_data,
   input  logic                   frame_done,
   output logic                   mem_we,
   output logic [ROW_W+COL_W:0]   mem_waddr,
   output logic [11:0]            mem_wdata,
   output logic                   front,
   output logic                   swap_pending,
   output logic [7:0]             frame_cnt
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   fb_state_e        state, state_next;
   logic             vs_d, vs_rise;
   logic             accept, in_range, swap, clearing;
   logic [ROW_W-1:0] clr_row;
   logic [COL_W-1:0] clr_col;

   assign vs_rise  = vs & ~vs_d;
   assign wr_ready = (state == ST_RENDER);
   assign accept   = wr_valid & wr_ready;
   assign in_range = (wr_col <= COL_LAST) && (wr_row <= ROW_LAST);
   assign swap     = (state == ST_PENDING) && vs_rise;

`ifdef FB_CLEAR_EN
   logic clr_busy, clr_last;

   fb_clear_seq #(
      .COL_W (COL_W),
      .ROW_W (ROW_W),
      .COLS  (COLS),
      .ROWS  (ROWS)
   ) u_clear_seq (
      .vga_clk (vga_clk),
      .rst     (rst),
      .start   (swap),
      .row     (clr_row),
      .col     (clr_col),
      .busy    (clr_busy),
      .last    (clr_last)
   );

   assign clearing = (state == ST_CLEAR) && clr_busy;
`else
   assign clr_row  = '0;
   assign clr_col  = '0;
   assign clearing = 1'b0;
`endif

   // vs_d resets high so a vs already high at reset release is not seen as an edge.
   always_ff @(posedge vga_clk or negedge rst) begin
      if (!rst) begin
         vs_d      <= 1'b1;
         state     <= ST_RENDER;
         front     <= 1'b0;
         frame_cnt <= '0;
      end else begin
         vs_d  <= vs;
         state <= state_next;
         if (swap) begin
            front     <= ~front;
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      case (state)
         ST_RENDER:  if (frame_done) state_next = ST_PENDING;
`ifdef FB_CLEAR_EN
         ST_PENDING: if (vs_rise) state_next = ST_CLEAR;
         ST_CLEAR:   if (clr_last) state_next = ST_RENDER;
`else
         ST_PENDING: if (vs_rise) state_next = ST_RENDER;
`endif
         default:    state_next = ST_RENDER;
      endcase
   end

   // Write port register; dropped out-of-range writes leave address and data untouched.
   always_ff @(posedge vga_clk or negedge rst) begin
      if (!rst) begin
         mem_we    <= 1'b0;
         mem_waddr <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= 1'b0;
         if (clearing) begin
            mem_we    <= 1'b1;
            mem_waddr <= {~front, clr_row, clr_col};
            mem_wdata <= BG_COLOR;
         end else if (accept && in_range) begin
            mem_we    <= 1'b1;
            mem_waddr <= {~front, wr_row, wr_col};
            mem_wdata <= wr_data;
         end
      end
   end

   assign rd_addr      = {front, scan_row, scan_col};
   assign swap_pending = (state == ST_PENDING);

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed bench for fb_swap_ctrl: writes, range drops, swap timing, coincident frame_done/vs_rise, resets.
// Clear-sequence checks are compiled when FB_CLEAR_EN is defined.
module tb_fb_swap_ctrl;

   logic        vga_clk = 1'b0;
   logic        rst;
   logic        vs;
   logic [6:0]  scan_col;
   logic [5:0]  scan_row;
   logic [13:0] rd_addr;
   logic        wr_valid;
   logic        wr_ready;
   logic [6:0]  wr_col;
   logic [5:0]  wr_row;
   logic [11:0] wr_data;
   logic        frame_done;
   logic        mem_we;
   logic [13:0] mem_waddr;
   logic [11:0] mem_wdata;
   logic        front;
   logic        swap_pending;
   logic [7:0]  frame_cnt;

   int checks = 0;
   int errors = 0;

   fb_swap_ctrl dut (
      .vga_clk      (vga_clk),
      .rst          (rst),
      .vs           (vs),
      .scan_col     (scan_col),
      .scan_row     (scan_row),
      .rd_addr      (rd_addr),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_col       (wr_col),
      .wr_row       (wr_row),
      .wr_data      (wr_data),
      .frame_done   (frame_done),
      .mem_we       (mem_we),
      .mem_waddr    (mem_waddr),
      .mem_wdata    (mem_wdata),
      .front        (front),
      .swap_pending (swap_pending),
      .frame_cnt    (frame_cnt)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic step();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_front"},   32'(front),        32'd0);
      check({tag, "_ready"},   32'(wr_ready),     32'd1);
      check({tag, "_we"},      32'(mem_we),       32'd0);
      check({tag, "_waddr"},   32'(mem_waddr),    32'd0);
      check({tag, "_wdata"},   32'(mem_wdata),    32'd0);
      check({tag, "_pending"}, 32'(swap_pending), 32'd0);
      check({tag, "_fcnt"},    32'(frame_cnt),    32'd0);
   endtask

   initial begin
      rst        = 1'b0;
      vs         = 1'b1;
      scan_col   = 7'd9;
      scan_row   = 6'd7;
      wr_valid   = 1'b0;
      wr_col     = '0;
      wr_row     = '0;
      wr_data    = '0;
      frame_done = 1'b0;
      #12;
      check_reset_values("rst_in");
      step();
      rst = 1'b1;
      step();
      step();
      check("vs_high_no_swap", 32'(front), 32'd0);
      check_reset_values("rst_out");

      // In-range write to back bank 1
      wr_valid = 1'b1; wr_col = 7'd5; wr_row = 6'd3; wr_data = 12'hABC;
      step();
      wr_valid = 1'b0;
      check("wr_we",    32'(mem_we),    32'd1);
      check("wr_waddr", 32'(mem_waddr), 32'h2185);
      check("wr_wdata", 32'(mem_wdata), 32'hABC);
      step();
      check("wr_we_one_cycle", 32'(mem_we), 32'd0);

      // Corner address, then out-of-range column and row
      wr_valid = 1'b1; wr_col = 7'd79; wr_row = 6'd59; wr_data = 12'h321;
      step();
      check("corner_we",    32'(mem_we),    32'd1);
      check("corner_waddr", 32'(mem_waddr), 32'h3DCF);
      wr_col = 7'd80; wr_row = 6'd0; wr_data = 12'hFFF;
      check("col80_ready", 32'(wr_ready), 32'd1);
      step();
      check("col80_dropped", 32'(mem_we), 32'd0);
      wr_col = 7'd0; wr_row = 6'd60;
      step();
      wr_valid = 1'b0;
      check("row60_dropped", 32'(mem_we), 32'd0);

      // Write coincident with frame_done completes, then PENDING
      wr_valid = 1'b1; wr_col = 7'd1; wr_row = 6'd2; wr_data = 12'h123; frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      wr_col = 7'd0; wr_row = 6'd0; wr_data = 12'h777;
      check("fd_wr_we",      32'(mem_we),       32'd1);
      check("fd_wr_waddr",   32'(mem_waddr),    32'h2101);
      check("fd_pending",    32'(swap_pending), 32'd1);
      check("fd_ready_low",  32'(wr_ready),     32'd0);
      step();
      wr_valid = 1'b0;
      check("pend_no_accept", 32'(mem_we), 32'd0);
      frame_done = 1'b1;
      vs = 1'b0;
      step();
      frame_done = 1'b0;
      step();
      check("pend_front_hold", 32'(front),    32'd0);
      check("pend_ready_low",  32'(wr_ready), 32'd0);
      vs = 1'b1;
      check("pre_swap_rd_addr", 32'(rd_addr), 32'h0389);
      step();
      check("swap_front",   32'(front),        32'd1);
      check("swap_fcnt",    32'(frame_cnt),    32'd1);
      check("swap_rd_addr", 32'(rd_addr),      32'h2389);
      check("swap_pending", 32'(swap_pending), 32'd0);
      scan_col = 7'd79; scan_row = 6'd59;
      #1;
      check("rd_addr_comb", 32'(rd_addr), 32'h3DCF);

`ifdef FB_CLEAR_EN
      begin
         int bad = 0;
         check("clear_ready_low", 32'(wr_ready), 32'd0);
         for (int i = 0; i < 4800; i++) begin
            step();
            if (mem_we !== 1'b1 || mem_wdata !== 12'h000 ||
                mem_waddr !== {1'b0, 6'(i / 80), 7'(i % 80)} ||
                (i < 4799 && wr_ready !== 1'b0))
               bad++;
         end
         check("clear_seq_bad", 32'(bad), 32'd0);
         check("clear_last_addr", 32'(mem_waddr), 32'h1DCF);
         check("clear_done_ready", 32'(wr_ready), 32'd1);
         step();
         check("clear_stop_we", 32'(mem_we), 32'd0);
      end
`else
      check("noclear_ready", 32'(wr_ready), 32'd1);
      step();
      check("noclear_no_we", 32'(mem_we), 32'd0);
`endif

      // Writes now target bank 0
      wr_valid = 1'b1; wr_col = 7'd2; wr_row = 6'd2; wr_data = 12'h5A5;
      step();
      wr_valid = 1'b0;
      check("bank0_waddr", 32'(mem_waddr), 32'h0102);
      check("bank0_wdata", 32'(mem_wdata), 32'h5A5);

      // frame_done coincident with vs_rise: swap waits for the next edge
      vs = 1'b0;
      step();
      vs = 1'b1; frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      check("coinc_front_hold", 32'(front),        32'd1);
      check("coinc_pending",    32'(swap_pending), 32'd1);
      step();
      check("coinc_still_pend", 32'(swap_pending), 32'd1);
      vs = 1'b0;
      step();
      vs = 1'b1;
      step();
      check("swap2_front", 32'(front),     32'd0);
      check("swap2_fcnt",  32'(frame_cnt), 32'd2);

`ifdef FB_CLEAR_EN
      for (int i = 0; i < 10; i++) step();
      check("midclear_we",   32'(mem_we),         32'd1);
      check("midclear_bank", 32'(mem_waddr[13]),  32'd1);
`else
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      check("midpend_pending", 32'(swap_pending), 32'd1);
`endif
      #2;
      rst = 1'b0;
      #1;
      check_reset_values("abort");
      step();
      rst = 1'b1;
      step();
      check_reset_values("abort_rel");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
